pipeline_ctrl: RTL and testbench

Hazard and forwarding controller for the 5-stage core. It sequences the execution stage: it drives the ALU/store operand selects, the stage clock enables and the flush strobes. It keeps a shadow pipeline of destination-register tags (EX, MA, WB) in step with the datapath. It sits between instruction decode and the execution stage, and is the only source of stall and flush in the core.

---
 rtl/riscv_definitions.sv | 32 +++
 rtl/pipeline_ctrl_fwd_select.sv | 25 ++
 rtl/pipeline_ctrl.sv | 115 +++++++++++
 tb/tb_pipeline_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_definitions.sv
// Shared core types: register addresses, operand-select encodings and shadow stage tags.
package riscv_definitions;

    typedef logic [4:0] regAddr_t;

    typedef enum logic [1:0] {
        RS1_S1   = 2'd0,
        RD_MA_S1 = 2'd1,
        RD_WB_S1 = 2'd2,
        PC_S1    = 2'd3
    } ctrlAluSrc1_e;

    typedef enum logic [1:0] {
        RS2_S2   = 2'd0,
        RD_MA_S2 = 2'd1,
        RD_WB_S2 = 2'd2,
        IMM_S2   = 2'd3
    } ctrlAluSrc2_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MA   = 2'd1,
        FWD_WB   = 2'd2
    } fwdSel_e;

    typedef struct packed {
        regAddr_t rd;
        logic     wr_en;
        logic     ld;
    } stageTag_t;

endpackage

// File: rtl/pipeline_ctrl_fwd_select.sv
// Priority compare of one source register against the instructions heading to MA and WB.
module fwd_select
    import riscv_definitions::*;
(
    input  regAddr_t rs_addr,
    input  regAddr_t ma_rd,
    input  logic     ma_wr,
    input  regAddr_t wb_rd,
    input  logic     wb_wr,
    output fwdSel_e  sel
);

    always_comb begin
        sel = FWD_NONE;
        // x0 is hardwired zero, so it never forwards
        if (rs_addr != '0) begin
            if (ma_wr && (ma_rd == rs_addr)) begin
                sel = FWD_MA;
            end else if (wb_wr && (wb_rd == rs_addr)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and forwarding controller: stage enables, flushes, load-use stall and
// registered operand selects, with a shadow pipeline of destination tags.
module pipeline_ctrl
    import riscv_definitions::*;
(
    input  logic         clk,
    input  logic         rst,
    input  regAddr_t     rs1_addr_id,
    input  regAddr_t     rs2_addr_id,
    input  logic         rs1_used_id,
    input  logic         rs2_used_id,
    input  logic         src1_pc_id,
    input  logic         src2_imm_id,
    input  regAddr_t     rd0_addr_id,
    input  logic         rd0_wr_en_id,
    input  logic         data_rd_en_id,
    input  logic         branch_taken,
    input  logic         mem_wait,
    output ctrlAluSrc1_e alu_src1,
    output ctrlAluSrc2_e alu_src2,
    output ctrlAluSrc2_e storage_src,
    output logic         clk_en_if_id,
    output logic         clk_en_id_ex,
    output logic         clk_en_ex_ma,
    output logic         clk_en_ma_wb,
    output logic         flush_if_id,
    output logic         flush_id_ex,
    output logic         load_use_stall
);

    stageTag_t    ex_q, ma_q, wb_q;
    fwdSel_e      sel1, sel2;
    ctrlAluSrc1_e alu_src1_d;
    ctrlAluSrc2_e alu_src2_d, storage_d;
    logic         bubble;

    always_comb begin
        load_use_stall = ex_q.ld && ex_q.wr_en && (ex_q.rd != '0) &&
                         ((rs1_used_id && (rs1_addr_id == ex_q.rd)) ||
                          (rs2_used_id && (rs2_addr_id == ex_q.rd))) &&
                         !branch_taken;
        bubble       = load_use_stall || branch_taken;
        clk_en_id_ex = !mem_wait;
        clk_en_ex_ma = !mem_wait;
        clk_en_ma_wb = !mem_wait;
        clk_en_if_id = !mem_wait && !load_use_stall;
        flush_if_id  = !mem_wait && branch_taken;
        flush_id_ex  = !mem_wait && bubble;
    end

    fwd_select u_fwd_rs1 (
        .rs_addr (rs1_addr_id),
        .ma_rd   (ex_q.rd),
        .ma_wr   (ex_q.wr_en),
        .wb_rd   (ma_q.rd),
        .wb_wr   (ma_q.wr_en),
        .sel     (sel1)
    );

    fwd_select u_fwd_rs2 (
        .rs_addr (rs2_addr_id),
        .ma_rd   (ex_q.rd),
        .ma_wr   (ex_q.wr_en),
        .wb_rd   (ma_q.rd),
        .wb_wr   (ma_q.wr_en),
        .sel     (sel2)
    );

    always_comb begin
        alu_src1_d = RS1_S1;
        storage_d  = RS2_S2;
        if (src1_pc_id) begin
            alu_src1_d = PC_S1;
        end else begin
            case (sel1)
                FWD_MA:  alu_src1_d = RD_MA_S1;
                FWD_WB:  alu_src1_d = RD_WB_S1;
                default: alu_src1_d = RS1_S1;
            endcase
        end
        case (sel2)
            FWD_MA:  storage_d = RD_MA_S2;
            FWD_WB:  storage_d = RD_WB_S2;
            default: storage_d = RS2_S2;
        endcase
        alu_src2_d = src2_imm_id ? IMM_S2 : storage_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_src1    <= RS1_S1;
            alu_src2    <= RS2_S2;
            storage_src <= RS2_S2;
            ex_q        <= '0;
            ma_q        <= '0;
            wb_q        <= '0;
        end else if (clk_en_id_ex) begin
            if (flush_id_ex) begin
                alu_src1    <= RS1_S1;
                alu_src2    <= RS2_S2;
                storage_src <= RS2_S2;
            end else begin
                alu_src1    <= alu_src1_d;
                alu_src2    <= alu_src2_d;
                storage_src <= storage_d;
            end
            ex_q.rd    <= rd0_addr_id;
            ex_q.wr_en <= rd0_wr_en_id && !bubble;
            ex_q.ld    <= data_rd_en_id && !bubble;
            ma_q       <= ex_q;
            wb_q       <= ma_q;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl with a queue-based scoreboard and monitor.
module tb_pipeline_ctrl;
    import riscv_definitions::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    regAddr_t     rs1_addr_id = '0, rs2_addr_id = '0, rd0_addr_id = '0;
    logic         rs1_used_id = 1'b0, rs2_used_id = 1'b0;
    logic         src1_pc_id = 1'b0, src2_imm_id = 1'b0;
    logic         rd0_wr_en_id = 1'b0, data_rd_en_id = 1'b0;
    logic         branch_taken = 1'b0, mem_wait = 1'b0;
    ctrlAluSrc1_e alu_src1;
    ctrlAluSrc2_e alu_src2, storage_src;
    logic         clk_en_if_id, clk_en_id_ex, clk_en_ex_ma, clk_en_ma_wb;
    logic         flush_if_id, flush_id_ex, load_use_stall;
    logic         mid_sample = 1'b0;

    pipeline_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rs1_addr_id    (rs1_addr_id),
        .rs2_addr_id    (rs2_addr_id),
        .rs1_used_id    (rs1_used_id),
        .rs2_used_id    (rs2_used_id),
        .src1_pc_id     (src1_pc_id),
        .src2_imm_id    (src2_imm_id),
        .rd0_addr_id    (rd0_addr_id),
        .rd0_wr_en_id   (rd0_wr_en_id),
        .data_rd_en_id  (data_rd_en_id),
        .branch_taken   (branch_taken),
        .mem_wait       (mem_wait),
        .alu_src1       (alu_src1),
        .alu_src2       (alu_src2),
        .storage_src    (storage_src),
        .clk_en_if_id   (clk_en_if_id),
        .clk_en_id_ex   (clk_en_id_ex),
        .clk_en_ex_ma   (clk_en_ex_ma),
        .clk_en_ma_wb   (clk_en_ma_wb),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .load_use_stall (load_use_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, pc, imm, wr, ld, br, mw;
        logic [1:0] a1, a2, ss;
        logic [3:0] en;  // {if_id, id_ex, ex_ma, ma_wb}
        logic [1:0] fl;  // {if_id, id_ex}
        logic       st;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   tests  = 0;
    int   errors = 0;

    function automatic vec_t mk(string n, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic pc, logic imm, logic [4:0] rd, logic wr, logic ld,
                                logic br, logic mw, logic [1:0] a1, logic [1:0] a2,
                                logic [1:0] ss, logic [3:0] en, logic [1:0] fl, logic st);
        vec_t v;
        v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.pc = pc; v.imm = imm;
        v.rd = rd; v.wr = wr; v.ld = ld; v.br = br; v.mw = mw;
        v.a1 = a1; v.a2 = a2; v.ss = ss; v.en = en; v.fl = fl; v.st = st;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rs1_addr_id   = v.rs1;
        rs2_addr_id   = v.rs2;
        rs1_used_id   = v.u1;
        rs2_used_id   = v.u2;
        src1_pc_id    = v.pc;
        src2_imm_id   = v.imm;
        rd0_addr_id   = v.rd;
        rd0_wr_en_id  = v.wr;
        data_rd_en_id = v.ld;
        branch_taken  = v.br;
        mem_wait      = v.mw;
    endtask

    // Monitor: pops one expectation per sample point and compares every output
    initial begin
        vec_t       e;
        logic [3:0] en_a;
        logic [1:0] fl_a;
        forever begin
            @(negedge clk or posedge mid_sample);
            if (sb.size() > 0) begin
                e    = sb.pop_front();
                en_a = {clk_en_if_id, clk_en_id_ex, clk_en_ex_ma, clk_en_ma_wb};
                fl_a = {flush_if_id, flush_id_ex};
                tests++;
                if (alu_src1 !== e.a1 || alu_src2 !== e.a2 || storage_src !== e.ss ||
                    en_a !== e.en || fl_a !== e.fl || load_use_stall !== e.st) begin
                    errors++;
                    $display("FAIL %s: got a1=%0d a2=%0d ss=%0d en=%b fl=%b st=%b, want a1=%0d a2=%0d ss=%0d en=%b fl=%b st=%b",
                             e.name, alu_src1, alu_src2, storage_src, en_a, fl_a, load_use_stall,
                             e.a1, e.a2, e.ss, e.en, e.fl, e.st);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        //               name           rs1 rs2 u1 u2 pc im rd wr ld br mw  a1 a2 ss  en      fl     st
        vecs.push_back(mk("reset_idle",   0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("add_x5",       1,  2, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("sub_rd_x5",    5,  3, 1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("and_rd_x5",    5,  4, 1, 1, 0, 0,10, 1, 0, 0, 0, 1, 0, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("lw_x7",        1,  0, 1, 0, 0, 1, 7, 1, 1, 0, 0, 2, 0, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("lu_stall",     7,  1, 1, 1, 0, 0, 8, 1, 0, 0, 0, 0, 3, 0, 4'h7, 2'b01, 1));
        vecs.push_back(mk("lu_retry",     7,  1, 1, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("x0_write1",    0,  0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 2, 0, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("x0_write2",    1,  2, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("x0_read",      0,  0, 1, 1, 0, 0,11, 1, 0, 0, 0, 0, 0, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("addi_x9",      1,  0, 1, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("sw_x9",        2,  9, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("lw_x12",       1,  0, 1, 0, 0, 1,12, 1, 1, 0, 0, 0, 3, 1, 4'hF, 2'b00, 0));
        vecs.push_back(mk("br_wait1",    12,  1, 1, 1, 0, 0,13, 1, 0, 1, 1, 0, 3, 0, 4'h0, 2'b00, 0));
        vecs.push_back(mk("br_wait2",    12,  1, 1, 1, 0, 0,13, 1, 0, 1, 1, 0, 3, 0, 4'h0, 2'b00, 0));
        vecs.push_back(mk("br_wait3",    12,  1, 1, 1, 0, 0,13, 1, 0, 1, 1, 0, 3, 0, 4'h0, 2'b00, 0));
        vecs.push_back(mk("br_release",  12,  1, 1, 1, 0, 0,13, 1, 0, 1, 0, 0, 3, 0, 4'hF, 2'b11, 0));
        vecs.push_back(mk("post_branch", 12,  0, 1, 1, 0, 0,14, 1, 0, 0, 0, 0, 0, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("auipc_x15",    0,  0, 0, 0, 1, 1,15, 1, 0, 0, 0, 2, 0, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("pc_imm_sel",   0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("lw_x7_again",  1,  0, 1, 0, 0, 1, 7, 1, 1, 0, 0, 0, 0, 0, 4'hF, 2'b00, 0));
        vecs.push_back(mk("lu_stall2",    7,  1, 1, 1, 0, 0, 8, 1, 0, 0, 0, 0, 3, 0, 4'h7, 2'b01, 1));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            sb.push_back(vecs[i]);
        end

        // Reset pulse in the middle of the stall cycle, sampled before any clock edge
        @(negedge clk);
        #1 rst = 1'b1;
        v = mk("rst_mid_stall", 7, 1, 1, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 4'hF, 2'b00, 0);
        sb.push_back(v);
        #1 mid_sample = 1'b1;
        #1 mid_sample = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        v = mk("post_rst", 7, 1, 1, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 4'hF, 2'b00, 0);
        sb.push_back(v);

        @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
